sal_rd_resp_buf: RTL

//  Read-return stage between the DFI read-data port and the AXI R channel, downstream of the scheduler.

---
 rtl/sal_rd_resp_buf_pkg.sv | 18 +
 rtl/sal_sync_fifo.sv | 61 ++++++
 rtl/sal_rd_resp_buf.sv | 135 +++++++++++++
 3 files changed

// File: rtl/sal_rd_resp_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module : sal_rd_resp_buf_pkg
// Brief  : Shared types and constants for the read-return buffer.
// Rev    : 1.0  initial release
// ============================================================================
package sal_rd_resp_buf_pkg;

    localparam int         SAL_ID_W   = 4;
    localparam logic [1:0] RRESP_OKAY = 2'b00;

    typedef struct packed {
        logic [SAL_ID_W-1:0] id;
        logic                last;
    } rd_tag_t;

endpackage
`default_nettype wire

// File: rtl/sal_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : sal_sync_fifo
// Brief  : Single-clock FIFO, power-of-2 depth, head read from storage flops.
// Rev    : 1.0  initial release
// ============================================================================
module sal_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Extra pointer bit distinguishes full from empty when the indices match.
    always_comb begin
        empty_o  = (wr_ptr_q == rd_ptr_q);
        full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        dout_o   = mem_q[rd_ptr_q[AW-1:0]];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push_i && !full_o) begin
            mem_d[wr_ptr_q[AW-1:0]] = din_i;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_i && !empty_o) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/sal_rd_resp_buf.sv
`default_nettype none
// ============================================================================
// Module : sal_rd_resp_buf
// Brief  : DFI read-data to AXI R return buffer with scheduler credits.
//          Optional same-cycle bypass when SAL_RD_BYPASS_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module sal_rd_resp_buf
    import sal_rd_resp_buf_pkg::*;
#(
    parameter int ID_W        = SAL_ID_W,  // must match the package tag width
    parameter int DATA_W      = 64,
    parameter int BURST_BEATS = 4,
    parameter int TAG_DEPTH   = 8,
    parameter int DATA_DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_cmd_valid_i,
    input  logic [ID_W-1:0]   rd_cmd_id_i,
    input  logic              rd_cmd_last_i,
    output logic              rd_cmd_ready_o,
    input  logic              dfi_rddata_valid_i,
    input  logic [DATA_W-1:0] dfi_rddata_i,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic [ID_W-1:0]   rid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [1:0]        rresp_o,
    output logic              rlast_o,
    output logic              err_o
);

    localparam int             CW         = $clog2(DATA_DEPTH + 1);
    localparam int             BCW        = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam logic [CW-1:0]  BURST_CRED = CW'(BURST_BEATS);
    localparam logic [CW-1:0]  FULL_CRED  = CW'(DATA_DEPTH);
    localparam logic [BCW-1:0] LAST_BEAT  = BCW'(BURST_BEATS - 1);

    logic [CW-1:0]     credit_q, credit_d;
    logic [BCW-1:0]    beat_cnt_q, beat_cnt_d;
    logic              err_q, err_d;
    logic              alive_q, alive_d;

    rd_tag_t           tag_din, tag_head;
    logic              tag_push, tag_pop, tag_full, tag_empty;
    logic              data_push, data_pop, data_full, data_empty;
    logic [DATA_W-1:0] data_head;
    logic              cmd_accept, r_hs, bypass, orphan, overflow, last_beat;

    sal_sync_fifo #(.WIDTH($bits(rd_tag_t)), .DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (tag_push),
        .din_i   (tag_din),
        .pop_i   (tag_pop),
        .dout_o  (tag_head),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

    sal_sync_fifo #(.WIDTH(DATA_W), .DEPTH(DATA_DEPTH)) u_data_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (data_push),
        .din_i   (dfi_rddata_i),
        .pop_i   (data_pop),
        .dout_o  (data_head),
        .full_o  (data_full),
        .empty_o (data_empty)
    );

    always_comb begin
        // alive_q holds ready low through reset and releases it one edge later.
        rd_cmd_ready_o = alive_q && !tag_full && (credit_q >= BURST_CRED);
        cmd_accept     = rd_cmd_valid_i && rd_cmd_ready_o;
        tag_din.id     = rd_cmd_id_i;
        tag_din.last   = rd_cmd_last_i;

`ifdef SAL_RD_BYPASS_EN
        bypass = data_empty && !tag_empty && dfi_rddata_valid_i;
`else
        bypass = 1'b0;
`endif

        last_beat = (beat_cnt_q == LAST_BEAT);
        rvalid_o  = (!data_empty && !tag_empty) || bypass;
        rdata_o   = bypass ? dfi_rddata_i : data_head;
        rid_o     = tag_head.id;
        rlast_o   = rvalid_o && tag_head.last && last_beat;
        rresp_o   = RRESP_OKAY;
        r_hs      = rvalid_o && rready_i;

        // With nothing outstanding every credit is home, so any beat is unsolicited.
        orphan    = dfi_rddata_valid_i && tag_empty && (credit_q == FULL_CRED);
        overflow  = dfi_rddata_valid_i && !orphan && data_full;
        data_push = dfi_rddata_valid_i && !orphan && !data_full && !(bypass && rready_i);
        data_pop  = r_hs && !bypass;
        tag_push  = cmd_accept;
        tag_pop   = r_hs && last_beat;

        credit_d = credit_q;
        if (r_hs && (credit_q != FULL_CRED)) begin
            credit_d = credit_d + CW'(1);
        end
        if (cmd_accept) begin
            credit_d = credit_d - BURST_CRED;
        end

        beat_cnt_d = beat_cnt_q;
        if (r_hs) begin
            beat_cnt_d = last_beat ? '0 : beat_cnt_q + BCW'(1);
        end

        err_d   = err_q || (rd_cmd_valid_i && !rd_cmd_ready_o) || orphan || overflow;
        alive_d = 1'b1;
        err_o   = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q   <= FULL_CRED;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
            alive_q    <= 1'b0;
        end else begin
            credit_q   <= credit_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
            alive_q    <= alive_d;
        end
    end

endmodule
`default_nettype wire
